mio_bus_responder: RTL and testbench

//  - Memory/IO-side responder for the single-cycle CPU's CPU_MIO / MIO_ready stall handshake.
//  - Accepts word load/store requests and inserts a configurable number of wait states.
//  - Decodes the address onto a data RAM, an LED register, a switch input port and a free-running cycle counter.
//  - Pulses mio_ready so the stalled CPU can retire the lw/sw.

---
 rtl/mio_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_mio_bus_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// ============================================================================
// Module      : mio_bus_responder
// Description : CPU_MIO/MIO_ready stall-handshake responder with wait states,
//               decoding a data RAM, LED register, switch port and cycle counter.
//               Optional macro MIO_RESP_ERR_EN enables access-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_bus_responder #(
  parameter int RAM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_mio,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mio_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        mio_err
);

  localparam int         AW     = $clog2(RAM_DEPTH);
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  localparam logic [29:0] c_sw_word  = 30'h3800_0000;
  localparam logic [29:0] c_led_word = 30'h3C00_0000;
  localparam logic [29:0] c_cnt_word = 30'h3C00_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [15:0] led_q, led_d;
  logic [31:0] cyc_q, cyc_d;

  logic [31:0] mem [RAM_DEPTH];

  logic          go_resp;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [31:0]   req_wdata;
  logic [AW-1:0] widx;
  logic          ram_hit, sw_hit, led_hit, cnt_hit;
  logic          fault;
  logic          ram_we;
  logic [31:0]   rd_word;

  // With zero wait states the response edge is the request edge, so the
  // live inputs feed the commit path instead of the latched copies.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    go_resp   = 1'b0;
    req_addr  = addr_q;
    req_we    = we_q;
    req_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_mio) begin
          addr_d  = addr;
          we_d    = mem_w;
          wdata_d = wdata;
          wcnt_d  = c_wait;
          if (c_wait == 4'd0) begin
            state_d   = ST_RESP;
            go_resp   = 1'b1;
            req_addr  = addr;
            req_we    = mem_w;
            req_wdata = wdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cpu_mio) begin
          state_d = ST_IDLE;
        end else if (wcnt_q <= 4'd1) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    widx    = req_addr[AW+1:2];
    ram_hit = (req_addr[31:AW+2] == '0);
    sw_hit  = (req_addr[31:2] == c_sw_word);
    led_hit = (req_addr[31:2] == c_led_word);
    cnt_hit = (req_addr[31:2] == c_cnt_word);
`ifdef MIO_RESP_ERR_EN
    fault = !(ram_hit || sw_hit || led_hit || cnt_hit) || (req_addr[1:0] != 2'b00);
`else
    fault = 1'b0;
`endif
    rd_word = 32'h0;
    if (ram_hit)      rd_word = mem[widx];
    else if (sw_hit)  rd_word = {16'h0, sw_in};
    else if (led_hit) rd_word = {16'h0, led_q};
    else if (cnt_hit) rd_word = cyc_q;

    ram_we  = rst_n && go_resp && req_we && ram_hit && !fault;
    led_d   = led_q;
    if (go_resp && req_we && led_hit && !fault) led_d = req_wdata[15:0];
    rdata_d = rdata_q;
    if (go_resp && !req_we) rdata_d = fault ? 32'h0 : rd_word;
    ready_d = go_resp;
    err_d   = go_resp && fault;
    cyc_d   = cyc_q + 32'd1;
  end

  // Byte-offset bits only matter when error reporting is built in.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 16'h0;
      cyc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      led_q   <= led_d;
      cyc_q   <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[widx] <= req_wdata;
  end

  assign rdata     = rdata_q;
  assign mio_ready = ready_q;
  assign led_out   = led_q;
  assign mio_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mio_bus_responder.sv
// ============================================================================
// Module      : tb_mio_bus_responder
// Description : Directed vector bench for mio_bus_responder (RAM_DEPTH=1024,
//               WAIT_CYCLES=2); follows MIO_RESP_ERR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mio_bus_responder;

  localparam int RAM_DEPTH   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef MIO_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_mio;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        mio_err;

  mio_bus_responder #(
    .RAM_DEPTH  (RAM_DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_mio  (cpu_mio),
    .mem_w    (mem_w),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .mio_ready(mio_ready),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .mio_err  (mio_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One handshake; inputs change on the falling edge, outputs are read there too.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er,
                         output logic [15:0] led, output int at_edge);
    int  lat;
    logic seen;
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = w; addr = a; wdata = d;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mio_ready === 1'b1) seen = 1'b1;
    end
    cpu_mio = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0;
    rd = rdata; er = mio_err; led = led_out; at_edge = edge_no;
    check("latency", 32'(lat), 32'(1 + WAIT_CYCLES));
    @(negedge clk);
    check("ready_pulse_width", {31'h0, mio_ready}, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] sw;
    logic        chk_rd;
    logic [31:0] rd;
    logic [15:0] led;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  logic [31:0] rd;
  logic        er;
  logic [15:0] ld;
  int          ke;
  int          ke2;
  int          rst_edge;
  logic        seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 16'hA5A5, 1'b0, 32'h0,         16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'hA5A5, 1'b1, 32'h1234_5678, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hF000_0000, 32'hABCD_00FF, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, 1'b0};
    vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0,         16'hA5A5, 1'b1, 32'h0000_00FF, 16'h00FF, 1'b0};
    vecs[4]  = '{1'b0, 32'hE000_0000, 32'h0,         16'hA5A5, 1'b1, 32'h0000_A5A5, 16'h00FF, 1'b0};
    vecs[5]  = '{1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, 1'b0};
    vecs[6]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h5A0F, 1'b1, 32'h0000_5A0F, 16'h00FF, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_BEEF, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         16'hA5A5, 1'b1, 32'h0BAD_BEEF, 16'h00FF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_1000, 32'h7777_7777, 16'hA5A5, 1'b0, 32'h0,         16'h00FF, ERR_EN};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         16'hA5A5, 1'b1, 32'h0000_0001, 16'h00FF, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_1000, 32'h0,         16'hA5A5, 1'b1, 32'h0,         16'h00FF, ERR_EN};
    vecs[14] = '{1'b0, 32'hF000_0008, 32'h0,         16'hA5A5, 1'b1, 32'h0,         16'h00FF, ERR_EN};
    vecs[15] = '{1'b0, 32'h0000_0020, 32'h0,         16'hA5A5, 1'b1, 32'h1111_2222, 16'h00FF, 1'b0};

    rst_n = 1'b0; cpu_mio = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; sw_in = 16'hA5A5;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ready", {31'h0, mio_ready}, 32'h0);
    check("reset_led",   {16'h0, led_out}, 32'h0);
    check("reset_err",   {31'h0, mio_err}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      sw_in = vecs[i].sw;
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, rd, er, ld, ke);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_led", i), {16'h0, ld}, {16'h0, vecs[i].led});
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
    end
    sw_in = 16'hA5A5;

    // Abort: cpu_mio drops in the first WAIT cycle of a store.
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_DEAD;
    @(negedge clk);
    cpu_mio = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mio_ready !== 1'b0) seen = 1'b1;
    end
    check("abort_no_ready", {31'h0, seen}, 32'h0);
    run_txn(1'b0, 32'h0000_0020, 32'h0, rd, er, ld, ke);
    check("abort_ram_unchanged", rd, 32'h1111_2222);

    // Reset asserted during WAIT of an LED store.
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'hF000_0000; wdata = 32'h0000_1234;
    @(negedge clk);
    rst_n = 1'b0; cpu_mio = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rst_edge = edge_no;
    check("midrst_led",   {16'h0, led_out}, 32'h0);
    check("midrst_ready", {31'h0, mio_ready}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mio_ready !== 1'b0 || led_out !== 16'h0) seen = 1'b1;
    end
    check("midrst_no_commit", {31'h0, seen}, 32'h0);

    // Cycle counter restarts at the reset edge; value sampled at the RESP-entry edge.
    run_txn(1'b0, 32'hF000_0004, 32'h0, rd, er, ld, ke);
    check("cycle_cnt_first", rd, 32'(ke - 1 - rst_edge));
    run_txn(1'b0, 32'hF000_0004, 32'h0, rd, er, ld, ke2);
    check("cycle_cnt_second", rd, 32'(ke2 - 1 - rst_edge));
    run_txn(1'b0, 32'hF000_0000, 32'h0, rd, er, ld, ke);
    check("postrst_led_read", rd, 32'h0);

    // Misaligned store to RAM word 4.
    run_txn(1'b1, 32'h0000_0013, 32'hCAFE_F00D, rd, er, ld, ke);
    check("misalign_sw_err", {31'h0, er}, {31'h0, ERR_EN});
    run_txn(1'b0, 32'h0000_0010, 32'h0, rd, er, ld, ke);
    check("misalign_ram4", rd, ERR_EN ? 32'h1234_5678 : 32'hCAFE_F00D);
    check("aligned_lw_err", {31'h0, er}, 32'h0);
    run_txn(1'b0, 32'h0000_0013, 32'h0, rd, er, ld, ke);
    check("misalign_lw_rdata", rd, ERR_EN ? 32'h0 : 32'hCAFE_F00D);
    check("misalign_lw_err", {31'h0, er}, {31'h0, ERR_EN});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
